// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF / ON / BLINK / BREATHE
// modes driven from a shared PWM counter and per-channel period counters.
module led_pattern_gen #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 25,
   parameter int PWM_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [3:0]          cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [PWM_W-1:0]    cfg_level,
   output logic [CHANNELS-1:0] led,
   output logic [CHANNELS-1:0] wrap_pulse
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mode_t               mode   [CHANNELS];
   logic [CNT_W-1:0]    period [CHANNELS];
   logic [CNT_W-1:0]    cnt    [CHANNELS];
   logic [PWM_W-1:0]    level  [CHANNELS];
   logic [PWM_W-1:0]    bright [CHANNELS];
   logic [CHANNELS-1:0] phase;
   logic [CHANNELS-1:0] dir;
   logic [PWM_W-1:0]    pwm_cnt;

   logic                cfg_accept;
   logic [CHANNELS-1:0] wrap_now;
   logic [CHANNELS-1:0] led_next;

   // All-ones level is solid on; otherwise a plain duty-cycle compare.
   function automatic logic pwm_on(input logic [PWM_W-1:0] x, input logic [PWM_W-1:0] ramp);
      return (x == '1) || (ramp < x);
   endfunction

   assign cfg_accept = cfg_valid && cfg_ready && (32'(cfg_chan) < CHANNELS);

   always_comb begin
      wrap_now = '0;
      led_next = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wrap_now[i] = ((mode[i] == MODE_BLINK) || (mode[i] == MODE_BREATHE)) && (cnt[i] == period[i]);
         case (mode[i])
            MODE_ON:      led_next[i] = pwm_on(level[i], pwm_cnt);
            MODE_BLINK:   led_next[i] = phase[i] && pwm_on(level[i], pwm_cnt);
            MODE_BREATHE: led_next[i] = pwm_on(bright[i], pwm_cnt);
            default:      led_next[i] = 1'b0;
         endcase
      end
   end

   // A config write to a channel wins over that channel's counter step, so
   // it also suppresses the wrap that would otherwise happen in that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_ready  <= 1'b0;
         led        <= '0;
         wrap_pulse <= '0;
         pwm_cnt    <= '0;
         phase      <= '0;
         dir        <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            mode[i]   <= MODE_OFF;
            period[i] <= '0;
            cnt[i]    <= '0;
            level[i]  <= '0;
            bright[i] <= '0;
         end
      end else begin
         cfg_ready <= 1'b1;
         pwm_cnt   <= pwm_cnt + PWM_ONE;
         led       <= led_next;
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_accept && (cfg_chan == 4'(i))) begin
               mode[i]       <= mode_t'(cfg_mode);
               period[i]     <= cfg_period;
               level[i]      <= cfg_level;
               cnt[i]        <= '0;
               bright[i]     <= '0;
               phase[i]      <= 1'b0;
               dir[i]        <= 1'b0;
               wrap_pulse[i] <= 1'b0;
            end else begin
               wrap_pulse[i] <= wrap_now[i];
               if ((mode[i] == MODE_BLINK) || (mode[i] == MODE_BREATHE)) begin
                  cnt[i] <= wrap_now[i] ? '0 : cnt[i] + CNT_ONE;
               end else begin
                  cnt[i] <= '0;
               end
               if (wrap_now[i] && (mode[i] == MODE_BLINK)) begin
                  phase[i] <= ~phase[i];
               end
               // Triangle ramp: turn around on reaching the peak or zero.
               if (wrap_now[i] && (mode[i] == MODE_BREATHE) && (level[i] != '0)) begin
                  if (!dir[i]) begin
                     bright[i] <= bright[i] + PWM_ONE;
                     if ((bright[i] + PWM_ONE) == level[i]) dir[i] <= 1'b1;
                  end else begin
                     bright[i] <= bright[i] - PWM_ONE;
                     if ((bright[i] - PWM_ONE) == '0) dir[i] <= 1'b0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a behavioural model queues the expected
// registered outputs for every cycle, which are popped and compared after the edge.
module tb_led_pattern_gen;

   localparam int CH    = 4;
   localparam int CNT_W = 25;
   localparam int PWM_W = 8;
   localparam int PMAX  = (1 << PWM_W) - 1;

   logic             clk;
   logic             rst;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [3:0]       cfg_chan;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_period;
   logic [PWM_W-1:0] cfg_level;
   logic [CH-1:0]    led;
   logic [CH-1:0]    wrap_pulse;

   led_pattern_gen #(.CHANNELS(CH), .CNT_W(CNT_W), .PWM_W(PWM_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_chan   (cfg_chan),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_level  (cfg_level),
      .led        (led),
      .wrap_pulse (wrap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0] led;
      logic [CH-1:0] wrap;
      logic          ready;
   } exp_t;

   exp_t sb[$];

   int compared   = 0;
   int mismatched = 0;

   int m_mode [CH];
   int m_p    [CH];
   int m_lvl  [CH];
   int m_c    [CH];
   int m_ph   [CH];
   int m_b    [CH];
   int m_dir  [CH];
   int m_pwm;
   int m_ready;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic logic model_pwm(input int x);
      return (x == PMAX) || (m_pwm < x);
   endfunction

   function automatic logic model_led(input int i);
      case (m_mode[i])
         1:       return model_pwm(m_lvl[i]);
         2:       return (m_ph[i] != 0) && model_pwm(m_lvl[i]);
         3:       return model_pwm(m_b[i]);
         default: return 1'b0;
      endcase
   endfunction

   // One clock: predict outputs, advance the model, then compare after the edge.
   task automatic stepCycle();
      exp_t e;
      exp_t got_e;
      logic acc;
      acc = !rst && cfg_valid && (m_ready != 0) && (cfg_chan < CH);
      e.led = '0;
      e.wrap = '0;
      e.ready = 1'b0;
      if (!rst) begin
         e.ready = 1'b1;
         for (int i = 0; i < CH; i++) begin
            e.led[i]  = model_led(i);
            e.wrap[i] = (m_mode[i] >= 2) && (m_c[i] == m_p[i]) && !(acc && (cfg_chan == i));
         end
      end
      sb.push_back(e);
      if (rst) begin
         m_ready = 0;
         m_pwm = 0;
         for (int i = 0; i < CH; i++) begin
            m_mode[i] = 0; m_p[i] = 0; m_lvl[i] = 0;
            m_c[i] = 0; m_ph[i] = 0; m_b[i] = 0; m_dir[i] = 0;
         end
      end else begin
         m_ready = 1;
         m_pwm = (m_pwm + 1) % (PMAX + 1);
         for (int i = 0; i < CH; i++) begin
            if (acc && (cfg_chan == i)) begin
               m_mode[i] = int'(cfg_mode);
               m_p[i] = int'(cfg_period);
               m_lvl[i] = int'(cfg_level);
               m_c[i] = 0; m_ph[i] = 0; m_b[i] = 0; m_dir[i] = 0;
            end else if (m_mode[i] >= 2) begin
               if (m_c[i] == m_p[i]) begin
                  m_c[i] = 0;
                  if (m_mode[i] == 2) m_ph[i] = 1 - m_ph[i];
                  else if (m_lvl[i] != 0) begin
                     if (m_dir[i] == 0) begin
                        m_b[i]++;
                        if (m_b[i] == m_lvl[i]) m_dir[i] = 1;
                     end else begin
                        m_b[i]--;
                        if (m_b[i] == 0) m_dir[i] = 0;
                     end
                  end
               end else begin
                  m_c[i]++;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checkOutput("sb_empty", 32'd0, 32'd1);
      end else begin
         got_e = sb.pop_front();
         checkOutput("led", 32'(led), 32'(got_e.led));
         checkOutput("wrap_pulse", 32'(wrap_pulse), 32'(got_e.wrap));
         checkOutput("cfg_ready", 32'(cfg_ready), 32'(got_e.ready));
      end
   endtask

   task automatic applyStimulus(input int chan, input int mode, input int period, input int level);
      cfg_valid  = 1'b1;
      cfg_chan   = 4'(chan);
      cfg_mode   = 2'(mode);
      cfg_period = CNT_W'(period);
      cfg_level  = PWM_W'(level);
      stepCycle();
      cfg_valid  = 1'b0;
   endtask

   int n_led;
   int n_wrap;
   int guard;

   initial begin
      rst = 1'b1;
      cfg_valid = 1'b1;
      cfg_chan = 4'd0;
      cfg_mode = 2'd1;
      cfg_period = '0;
      cfg_level = 8'd255;
      m_ready = 0;
      m_pwm = 0;
      for (int i = 0; i < CH; i++) begin
         m_mode[i] = 0; m_p[i] = 0; m_lvl[i] = 0;
         m_c[i] = 0; m_ph[i] = 0; m_b[i] = 0; m_dir[i] = 0;
      end

      // Reset held with a pending write: nothing may leak out
      for (int k = 0; k < 3; k++) stepCycle();
      rst = 1'b0;
      cfg_valid = 1'b0;
      stepCycle();
      checkOutput("ready_after_release", 32'(cfg_ready), 32'd1);

      // BLINK ch0, P=3: 8 wraps and 16 lit cycles in 32 clocks
      applyStimulus(0, 2, 3, 255);
      n_led = 0; n_wrap = 0;
      for (int k = 0; k < 32; k++) begin
         stepCycle();
         n_led += int'(led[0]);
         n_wrap += int'(wrap_pulse[0]);
      end
      checkOutput("blink_wraps", 32'(n_wrap), 32'd8);
      checkOutput("blink_on_cycles", 32'(n_led), 32'd16);

      // ON ch1 duty cycle at 64, 0 and full scale
      applyStimulus(1, 1, 0, 64);
      n_led = 0;
      for (int k = 0; k < 256; k++) begin stepCycle(); n_led += int'(led[1]); end
      checkOutput("on_duty_64", 32'(n_led), 32'd64);
      applyStimulus(1, 1, 0, 0);
      n_led = 0;
      for (int k = 0; k < 256; k++) begin stepCycle(); n_led += int'(led[1]); end
      checkOutput("on_duty_0", 32'(n_led), 32'd0);
      applyStimulus(1, 1, 0, 255);
      n_led = 0;
      for (int k = 0; k < 256; k++) begin stepCycle(); n_led += int'(led[1]); end
      checkOutput("on_duty_255", 32'(n_led), 32'd256);

      // BREATHE ch2, P=0, peak 3, then peak 0 stays dark
      applyStimulus(2, 3, 0, 3);
      n_wrap = 0;
      for (int k = 0; k < 24; k++) begin stepCycle(); n_wrap += int'(wrap_pulse[2]); end
      checkOutput("breathe_wraps", 32'(n_wrap), 32'd24);
      applyStimulus(2, 3, 0, 0);
      n_led = 0;
      for (int k = 0; k < 40; k++) begin stepCycle(); n_led += int'(led[2]); end
      checkOutput("breathe_zero_dark", 32'(n_led), 32'd0);

      // Rewrite ch0 exactly in its c==P cycle: the wrap is swallowed
      applyStimulus(0, 2, 5, 255);
      guard = 0;
      while ((m_c[0] != m_p[0]) && (guard < 100)) begin stepCycle(); guard++; end
      checkOutput("reach_wrap_cycle", 32'(guard < 100), 32'd1);
      applyStimulus(0, 2, 3, 200);
      checkOutput("rewrite_no_wrap", 32'(wrap_pulse[0]), 32'd0);
      for (int k = 0; k < 12; k++) stepCycle();

      // Out-of-range channel index is ignored
      applyStimulus(7, 1, 0, 255);
      for (int k = 0; k < 12; k++) stepCycle();

      // Reset in the middle of breathing on every channel
      for (int i = 0; i < CH; i++) applyStimulus(i, 3, 1, 5);
      for (int k = 0; k < 30; k++) stepCycle();
      rst = 1'b1;
      stepCycle();
      checkOutput("midreset_led", 32'(led), 32'd0);
      checkOutput("midreset_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0;
      stepCycle();
      applyStimulus(3, 2, 1, 255);
      n_wrap = 0;
      for (int k = 0; k < 20; k++) begin stepCycle(); n_wrap += int'(wrap_pulse[3]); end
      checkOutput("post_reset_wraps", 32'(n_wrap), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
